idex_hazard_stage: RTL and testbench

IDEX_HAZARD_STAGE -- requirements
Module: idex_hazard_stage

---
 rtl/idex_hazard_stage.sv | 163 ++++++++++++++++
 tb/tb_idex_hazard_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_hazard_stage.sv
// ---------------------------------------------------------------------------
// idex_hazard_stage
//   ID/EX pipeline register with load-use hazard detection and a
//   programmable bubble count.
//
//   When the instruction in EX writes a register that the instruction in ID
//   reads, the ID instruction is held (stall_if/stall_id) and LOAD_LAT
//   bubbles are pushed into EX. A flush kills the ID instruction and any
//   remaining bubble countdown. en=0 freezes every register.
//
//   Configuration macro: IDEX_FORWARD_EN
//     defined   : only loads in EX (ex_mem_read) create a hazard, because
//                 ALU results are forwarded downstream.
//     undefined : any register-writing instruction in EX (ex_reg_write_en)
//                 creates a hazard.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   en                    stage enable (0 = hold all state)
//   flush                 kill the ID instruction (insert bubble)
//   id_*                  decoded instruction fields from ID
//   ex_*                  registered copies presented to EX
//   stall_if, stall_id    hold PC and the IF/ID register (combinational)
//   perf_stall_cnt        saturating count of hazard/countdown bubbles
// ---------------------------------------------------------------------------
module idex_hazard_stage #(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc4,
    input  logic [XLEN-1:0]    id_op1,
    input  logic [XLEN-1:0]    id_op2,
    input  logic [3:0]         id_alu_sel,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_reg_write_en,
    input  logic               id_mem_read,
    input  logic               id_mem_req_write,
    input  logic               id_mem_req_type,
    input  logic [2:0]         id_wb_sel,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc4,
    output logic [XLEN-1:0]    ex_op1,
    output logic [XLEN-1:0]    ex_op2,
    output logic [3:0]         ex_alu_sel,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_reg_write_en,
    output logic               ex_mem_read,
    output logic               ex_mem_req_write,
    output logic               ex_mem_req_type,
    output logic [2:0]         ex_wb_sel,
    output logic               stall_if,
    output logic               stall_id,
    output logic [15:0]        perf_stall_cnt
);

    // Countdown reload: the hazard edge itself is the first bubble.
    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    logic [2:0] cnt_r;
    logic       ex_writer_s;
    logic       hazard_s;
    logic       stall_s;

    // True when a nonzero destination matches either source register.
    function automatic logic rs_match(input logic [RADDR_W-1:0] rd,
                                      input logic [RADDR_W-1:0] rs1,
                                      input logic [RADDR_W-1:0] rs2);
        return (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

    // Selects which EX control bit marks a result that cannot be forwarded.
    always_comb begin
`ifdef IDEX_FORWARD_EN
        ex_writer_s = ex_mem_read;
`else
        ex_writer_s = ex_reg_write_en;
`endif
    end

    // Hazard detection and stall generation; flush and reset mask the stall.
    always_comb begin
        hazard_s = id_valid & ex_valid & ex_writer_s & rs_match(ex_rd, id_rs1, id_rs2);
        stall_s  = (hazard_s | (cnt_r != 3'd0)) & ~flush & ~rst;
    end

    assign stall_if = stall_s;
    assign stall_id = stall_s;

    // ID/EX register, bubble countdown and stall performance counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid         <= 1'b0;
            ex_pc4           <= '0;
            ex_op1           <= '0;
            ex_op2           <= '0;
            ex_alu_sel       <= 4'd0;
            ex_rd            <= '0;
            ex_reg_write_en  <= 1'b0;
            ex_mem_read      <= 1'b0;
            ex_mem_req_write <= 1'b0;
            ex_mem_req_type  <= 1'b0;
            ex_wb_sel        <= 3'd0;
            cnt_r            <= 3'd0;
            perf_stall_cnt   <= 16'd0;
        end else if (en) begin
            if (flush || hazard_s || (cnt_r != 3'd0)) begin
                // Bubble: every EX field, including valid, goes to zero.
                ex_valid         <= 1'b0;
                ex_pc4           <= '0;
                ex_op1           <= '0;
                ex_op2           <= '0;
                ex_alu_sel       <= 4'd0;
                ex_rd            <= '0;
                ex_reg_write_en  <= 1'b0;
                ex_mem_read      <= 1'b0;
                ex_mem_req_write <= 1'b0;
                ex_mem_req_type  <= 1'b0;
                ex_wb_sel        <= 3'd0;
            end else begin
                ex_valid         <= id_valid;
                ex_pc4           <= id_pc4;
                ex_op1           <= id_op1;
                ex_op2           <= id_op2;
                ex_alu_sel       <= id_alu_sel;
                ex_rd            <= id_rd;
                ex_reg_write_en  <= id_reg_write_en;
                ex_mem_read      <= id_mem_read;
                ex_mem_req_write <= id_mem_req_write;
                ex_mem_req_type  <= id_mem_req_type;
                ex_wb_sel        <= id_wb_sel;
            end

            // Flush wins over any pending countdown and is not counted.
            if (flush) begin
                cnt_r <= 3'd0;
            end else if (cnt_r != 3'd0) begin
                cnt_r <= cnt_r - 3'd1;
            end else if (hazard_s) begin
                cnt_r <= LAT_M1;
            end else begin
                cnt_r <= 3'd0;
            end

            if (!flush && (hazard_s || (cnt_r != 3'd0)) && (perf_stall_cnt != 16'hFFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end else begin
                perf_stall_cnt <= perf_stall_cnt;
            end
        end else begin
            cnt_r          <= cnt_r;
            perf_stall_cnt <= perf_stall_cnt;
        end
    end

endmodule

// File: tb/tb_idex_hazard_stage.sv
// ---------------------------------------------------------------------------
// Directed testbench for idex_hazard_stage. Two instances share the ID-side
// stimulus: dut1 with LOAD_LAT=1 and dut3 with LOAD_LAT=3. Expectations for
// the back-to-back ALU case depend on IDEX_FORWARD_EN.
// ---------------------------------------------------------------------------
module tb_idex_hazard_stage;

    logic        clk;
    logic        rst;
    logic        en;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc4;
    logic [31:0] id_op1;
    logic [31:0] id_op2;
    logic [3:0]  id_alu_sel;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write_en;
    logic        id_mem_read;
    logic        id_mem_req_write;
    logic        id_mem_req_type;
    logic [2:0]  id_wb_sel;

    logic        a_valid, a_rwe, a_mrd, a_mwr, a_mty, a_sif, a_sid;
    logic [31:0] a_pc4, a_op1, a_op2;
    logic [3:0]  a_alu;
    logic [4:0]  a_rd;
    logic [2:0]  a_wb;
    logic [15:0] a_perf;

    logic        b_valid, b_rwe, b_mrd, b_mwr, b_mty, b_sif, b_sid;
    logic [31:0] b_pc4, b_op1, b_op2;
    logic [3:0]  b_alu;
    logic [4:0]  b_rd;
    logic [2:0]  b_wb;
    logic [15:0] b_perf;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    idex_hazard_stage #(.XLEN(32), .RADDR_W(5), .LOAD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .id_valid(id_valid), .id_pc4(id_pc4), .id_op1(id_op1), .id_op2(id_op2),
        .id_alu_sel(id_alu_sel), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write_en(id_reg_write_en), .id_mem_read(id_mem_read),
        .id_mem_req_write(id_mem_req_write), .id_mem_req_type(id_mem_req_type),
        .id_wb_sel(id_wb_sel),
        .ex_valid(a_valid), .ex_pc4(a_pc4), .ex_op1(a_op1), .ex_op2(a_op2),
        .ex_alu_sel(a_alu), .ex_rd(a_rd), .ex_reg_write_en(a_rwe),
        .ex_mem_read(a_mrd), .ex_mem_req_write(a_mwr), .ex_mem_req_type(a_mty),
        .ex_wb_sel(a_wb), .stall_if(a_sif), .stall_id(a_sid), .perf_stall_cnt(a_perf)
    );

    idex_hazard_stage #(.XLEN(32), .RADDR_W(5), .LOAD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .id_valid(id_valid), .id_pc4(id_pc4), .id_op1(id_op1), .id_op2(id_op2),
        .id_alu_sel(id_alu_sel), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write_en(id_reg_write_en), .id_mem_read(id_mem_read),
        .id_mem_req_write(id_mem_req_write), .id_mem_req_type(id_mem_req_type),
        .id_wb_sel(id_wb_sel),
        .ex_valid(b_valid), .ex_pc4(b_pc4), .ex_op1(b_op1), .ex_op2(b_op2),
        .ex_alu_sel(b_alu), .ex_rd(b_rd), .ex_reg_write_en(b_rwe),
        .ex_mem_read(b_mrd), .ex_mem_req_write(b_mwr), .ex_mem_req_type(b_mty),
        .ex_wb_sel(b_wb), .stall_if(b_sif), .stall_id(b_sid), .perf_stall_cnt(b_perf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc4, input logic [31:0] op1,
                          input logic [31:0] op2, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic mrd, input logic rwe,
                          input logic [2:0] wb);
        id_valid        = v;
        id_pc4          = pc4;
        id_op1          = op1;
        id_op2          = op2;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_rd           = rd;
        id_mem_read     = mrd;
        id_reg_write_en = rwe;
        id_wb_sel       = wb;
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; flush = 1'b0;
        id_alu_sel = 4'hA; id_mem_req_write = 1'b0; id_mem_req_type = 1'b1;
        set_id(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0);

        // Reset state
        rst = 1'b1;
        #1;
        check("rst_ex_valid", {31'd0, a_valid}, 32'd0);
        check("rst_ex_rd", {27'd0, a_rd}, 32'd0);
        check("rst_perf", {16'd0, a_perf}, 32'd0);
        check("rst_stall", {31'd0, a_sif}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Load-use: lw x5 then add x6,x5,x7
        set_id(1'b1, 32'h104, 32'h1000, 32'h0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 3'd1);
        check("lw_no_stall", {31'd0, a_sif}, 32'd0);
        step();
        check("lw_ex_valid", {31'd0, a_valid}, 32'd1);
        check("lw_ex_rd", {27'd0, a_rd}, 32'd5);
        check("lw_ex_pc4", a_pc4, 32'h104);
        check("lw_ex_op1", a_op1, 32'h1000);
        check("lw_ex_mrd", {31'd0, a_mrd}, 32'd1);
        check("lw_ex_alu", {28'd0, a_alu}, 32'hA);
        check("lw_ex_mty", {31'd0, a_mty}, 32'd1);
        check("lw_ex_wb", {29'd0, a_wb}, 32'd1);
        set_id(1'b1, 32'h108, 32'h0, 32'hAB, 5'd5, 5'd7, 5'd6, 1'b0, 1'b1, 3'd0);
        check("lu1_stall_if", {31'd0, a_sif}, 32'd1);
        check("lu1_stall_id", {31'd0, a_sid}, 32'd1);
        check("lu3_stall_c0", {31'd0, b_sif}, 32'd1);
        step();
        check("lu1_bubble", {31'd0, a_valid}, 32'd0);
        check("lu1_bubble_rd", {27'd0, a_rd}, 32'd0);
        check("lu1_perf", {16'd0, a_perf}, 32'd1);
        check("lu1_stall_off", {31'd0, a_sif}, 32'd0);
        check("lu3_bubble1", {31'd0, b_valid}, 32'd0);
        check("lu3_stall_c1", {31'd0, b_sid}, 32'd1);
        step();
        check("lu1_dep_rd", {27'd0, a_rd}, 32'd6);
        check("lu1_dep_op2", a_op2, 32'hAB);
        check("lu1_perf_hold", {16'd0, a_perf}, 32'd1);
        check("lu3_bubble2", {31'd0, b_valid}, 32'd0);
        check("lu3_perf2", {16'd0, b_perf}, 32'd2);
        check("lu3_stall_c2", {31'd0, b_sif}, 32'd1);
        step();
        check("lu3_bubble3", {31'd0, b_valid}, 32'd0);
        check("lu3_perf3", {16'd0, b_perf}, 32'd3);
        check("lu3_stall_end", {31'd0, b_sif}, 32'd0);
        step();
        check("lu3_dep_rd", {27'd0, b_rd}, 32'd6);
        check("lu3_dep_valid", {31'd0, b_valid}, 32'd1);

        // Back-to-back ALU on dut1: addi x10,x0,2 then addi x11 reading x10 via rs2
        set_id(1'b1, 32'h200, 32'h0, 32'h2, 5'd0, 5'd0, 5'd10, 1'b0, 1'b1, 3'd0);
        step();
        check("alu_ex_rd10", {27'd0, a_rd}, 32'd10);
        set_id(1'b1, 32'h204, 32'h0, 32'h2, 5'd0, 5'd10, 5'd11, 1'b0, 1'b1, 3'd0);
`ifdef IDEX_FORWARD_EN
        check("alu_stall", {31'd0, a_sif}, 32'd0);
        step();
        check("alu_ex_rd11", {27'd0, a_rd}, 32'd11);
        check("alu_perf", {16'd0, a_perf}, 32'd1);
`else
        check("alu_stall", {31'd0, a_sif}, 32'd1);
        step();
        check("alu_bubble", {31'd0, a_valid}, 32'd0);
        check("alu_perf", {16'd0, a_perf}, 32'd2);
`endif
        step();
        check("alu_ex_rd11_b", {27'd0, a_rd}, 32'd11);

        // Asynchronous reset clears counters mid-cycle
        rst = 1'b1;
        #1;
        check("arst_perf1", {16'd0, a_perf}, 32'd0);
        check("arst_perf3", {16'd0, b_perf}, 32'd0);
        check("arst_valid", {31'd0, a_valid}, 32'd0);
        check("arst_pc4", b_pc4, 32'd0);
        rst = 1'b0;
        step();

        // rd=0 writer followed by rs1=0 reader never stalls
        set_id(1'b1, 32'h300, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 3'd0);
        step();
        set_id(1'b1, 32'h304, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1, 3'd0);
        check("x0_stall1", {31'd0, a_sif}, 32'd0);
        check("x0_stall3", {31'd0, b_sif}, 32'd0);
        step();
        check("x0_ex_rd", {27'd0, b_rd}, 32'd3);

        // Flush during second of three stall cycles
        set_id(1'b1, 32'h400, 32'h0, 32'h0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 3'd1);
        step();
        set_id(1'b1, 32'h404, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, 1'b0, 1'b1, 3'd0);
        check("fl_stall_c0", {31'd0, b_sif}, 32'd1);
        step();
        check("fl_stall_c1", {31'd0, b_sif}, 32'd1);
        flush = 1'b1;
        #1;
        check("fl_stall_drop", {31'd0, b_sif}, 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("fl_bubble", {31'd0, b_valid}, 32'd0);
        check("fl_perf", {16'd0, b_perf}, 32'd1);
        check("fl_cnt_clear", {31'd0, b_sif}, 32'd0);
        step();
        check("fl_next_rd", {27'd0, b_rd}, 32'd6);

        // Reset mid-stall abandons remaining bubbles
        set_id(1'b1, 32'h500, 32'h0, 32'h0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 3'd1);
        step();
        set_id(1'b1, 32'h504, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, 1'b0, 1'b1, 3'd0);
        step();
        check("rs_mid_stall", {31'd0, b_sif}, 32'd1);
        rst = 1'b1;
        #1;
        check("rs_stall_low", {31'd0, b_sif}, 32'd0);
        check("rs_perf", {16'd0, b_perf}, 32'd0);
        rst = 1'b0;
        #1;
        check("rs_after_stall", {31'd0, b_sif}, 32'd0);
        step();
        check("rs_dep_rd", {27'd0, b_rd}, 32'd6);
        check("rs_dep_valid", {31'd0, b_valid}, 32'd1);

        // en=0 for four cycles mid-stall freezes everything
        set_id(1'b1, 32'h600, 32'h0, 32'h0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 3'd1);
        step();
        set_id(1'b1, 32'h604, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, 1'b0, 1'b1, 3'd0);
        step();
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("en0_stall", {31'd0, b_sif}, 32'd1);
            check("en0_perf", {16'd0, b_perf}, 32'd1);
            check("en0_valid", {31'd0, b_valid}, 32'd0);
        end
        en = 1'b1;
        step();
        check("en1_perf2", {16'd0, b_perf}, 32'd2);
        check("en1_stall", {31'd0, b_sif}, 32'd1);
        step();
        check("en1_perf3", {16'd0, b_perf}, 32'd3);
        check("en1_stall_end", {31'd0, b_sif}, 32'd0);
        step();
        check("en1_dep_rd", {27'd0, b_rd}, 32'd6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
